// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: IDLE/INIT/FETCH/DECODE/OPREAD/EXEC/MEM/WB/HALT, registered Moore strobes.
// Latency: 1 cycle per state, EXEC MULDIV_LAT cycles for mul/div/mod; MEM waits on memAck.
// Optional retired-instruction counter when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl #(
   parameter int OPC_W      = 5,
   parameter int MULDIV_LAT = 4
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [OPC_W-1:0] opcode,
   input  logic             flagE,
   input  logic             flagGt,
   input  logic             memAck,
   output logic             memReq,
   output logic             isLd,
   output logic             isSt,
   output logic             ldInst,
   output logic             ldNPC,
   output logic             ldDecodeInst,
   output logic             ldRegOutputData,
   output logic             ldResult,
   output logic             ldPC,
   output logic             wrFlag,
   output logic             isRegWriteback,
   output logic             rstRegFile,
   output logic             clrAll,
   output logic [2:0]       aluSel,
   output logic             isBranchTaken,
   output logic             isCall,
   output logic             isRet,
   output logic             busy,
   output logic             illegalOp
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0]      retired
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_FETCH, S_DECODE, S_OPREAD, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] MD_INIT = 4'(MULDIV_LAT - 1);

   state_t     state;
   logic [4:0] opc_q;
   logic [3:0] cnt;
   logic       opc_legal;

   // Full-width compare so any set upper bit makes the opcode illegal.
   assign opc_legal = (opcode < OPC_W'(21)) && (opcode != OPC_W'(13));

   function automatic logic [2:0] alu_of(input logic [4:0] op);
      case (op)
         5'd2:              alu_of = 3'd1;
         5'd3, 5'd4:        alu_of = 3'd2;
         5'd9:              alu_of = 3'd3;
         5'd6, 5'd7, 5'd8:  alu_of = 3'd4;
         5'd10, 5'd11, 5'd12: alu_of = 3'd5;
         default:           alu_of = 3'd0;
      endcase
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      is_muldiv = (op inside {5'd2, 5'd3, 5'd4});
   endfunction

   function automatic logic is_rwb(input logic [4:0] op);
      is_rwb = (op inside {[5'd0:5'd4], [5'd6:5'd12], 5'd14});
   endfunction

   function automatic logic br_taken(input logic [4:0] op, input logic fe, input logic fg);
      br_taken = (op inside {5'd18, 5'd19, 5'd20}) || (op == 5'd16 && fe) || (op == 5'd17 && fg);
   endfunction

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state           <= S_IDLE;
         opc_q           <= '0;
         cnt             <= '0;
         memReq          <= 1'b0;
         isLd            <= 1'b0;
         isSt            <= 1'b0;
         ldInst          <= 1'b0;
         ldNPC           <= 1'b0;
         ldDecodeInst    <= 1'b0;
         ldRegOutputData <= 1'b0;
         ldResult        <= 1'b0;
         ldPC            <= 1'b0;
         wrFlag          <= 1'b0;
         isRegWriteback  <= 1'b0;
         rstRegFile      <= 1'b0;
         clrAll          <= 1'b0;
         aluSel          <= 3'd0;
         isBranchTaken   <= 1'b0;
         isCall          <= 1'b0;
         isRet           <= 1'b0;
         busy            <= 1'b0;
         illegalOp       <= 1'b0;
      end else begin
         // Single-cycle strobes fall unless the destination state raises them.
         ldInst          <= 1'b0;
         ldNPC           <= 1'b0;
         ldDecodeInst    <= 1'b0;
         ldRegOutputData <= 1'b0;
         ldResult        <= 1'b0;
         ldPC            <= 1'b0;
         wrFlag          <= 1'b0;
         isRegWriteback  <= 1'b0;
         rstRegFile      <= 1'b0;
         clrAll          <= 1'b0;
         isCall          <= 1'b0;
         isRet           <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_INIT;
                  busy       <= 1'b1;
                  rstRegFile <= 1'b1;
                  clrAll     <= 1'b1;
               end
            end
            S_INIT: begin
               state  <= S_FETCH;
               ldInst <= 1'b1;
               ldNPC  <= 1'b1;
            end
            S_FETCH: begin
               state        <= S_DECODE;
               ldDecodeInst <= 1'b1;
            end
            S_DECODE: begin
               if (opc_legal) begin
                  state           <= S_OPREAD;
                  opc_q           <= opcode[4:0];
                  aluSel          <= alu_of(opcode[4:0]);
                  ldRegOutputData <= 1'b1;
               end else begin
                  state     <= S_HALT;
                  illegalOp <= 1'b1;
                  busy      <= 1'b0;
                  aluSel    <= 3'd0;
               end
            end
            S_OPREAD: begin
               state         <= S_EXEC;
               isBranchTaken <= br_taken(opc_q, flagE, flagGt);
               if (is_muldiv(opc_q) && MULDIV_LAT > 1) begin
                  cnt <= MD_INIT;
               end else begin
                  cnt      <= 4'd0;
                  ldResult <= 1'b1;
                  wrFlag   <= (opc_q == 5'd5);
               end
            end
            S_EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     ldResult <= 1'b1;
                     wrFlag   <= (opc_q == 5'd5);
                  end
               end else if (opc_q == 5'd14 || opc_q == 5'd15) begin
                  state  <= S_MEM;
                  memReq <= 1'b1;
                  isLd   <= (opc_q == 5'd14);
                  isSt   <= (opc_q == 5'd15);
               end else begin
                  state          <= S_WB;
                  ldPC           <= 1'b1;
                  isRegWriteback <= is_rwb(opc_q);
                  isCall         <= (opc_q == 5'd19);
                  isRet          <= (opc_q == 5'd20);
               end
            end
            S_MEM: begin
               if (memAck) begin
                  state          <= S_WB;
                  memReq         <= 1'b0;
                  isLd           <= 1'b0;
                  isSt           <= 1'b0;
                  ldPC           <= 1'b1;
                  isRegWriteback <= is_rwb(opc_q);
               end
            end
            S_WB: begin
               state         <= S_FETCH;
               ldInst        <= 1'b1;
               ldNPC         <= 1'b1;
               isBranchTaken <= 1'b0;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         retired <= 32'd0;
      end else if (state == S_WB) begin
         retired <= retired + 32'd1;
      end
   end
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OPC_W, default 5, opcode width (min 5).
REQ-002 SHALL have parameter MULDIV_LAT, default 4, EXEC cycles for opcodes 2/3/4 (1..15).
REQ-003 SHALL have ports clk in 1 (system clock); rstN in 1 (reset). One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports start in 1 (begin execution); opcode in OPC_W (from decode register); flagE in 1; flagGt in 1.
REQ-005 SHALL have ports memAck in 1 (data-memory done); memReq out 1 (data-memory request); isLd out 1; isSt out 1.
REQ-006 SHALL have ports ldInst, ldNPC, ldDecodeInst, ldRegOutputData, ldResult, ldPC, wrFlag, isRegWriteback out 1 each (register/flag load strobes).
REQ-007 SHALL have ports rstRegFile out 1 and clrAll out 1 (datapath clear); aluSel out 3 (ALU unit select); isBranchTaken, isCall, isRet out 1 each.
REQ-008 SHALL have ports busy out 1 (not IDLE/HALT) and illegalOp out 1 (sticky, undefined opcode seen).

Function
REQ-009 SHALL implement states IDLE, INIT, FETCH, DECODE, OPREAD, EXEC, MEM, WB and HALT, with all strobes Moore outputs of the current state.
REQ-010 SHALL leave IDLE for INIT when start=1 and ignore start in every other state.
REQ-011 SHALL, in INIT (1 cycle), assert rstRegFile=1 and clrAll=1, then go to FETCH.
REQ-012 SHALL, in FETCH (1 cycle), assert ldInst=1 and ldNPC=1, then go to DECODE.
REQ-013 SHALL, in DECODE (1 cycle), assert ldDecodeInst=1 and capture opcode, then go to OPREAD; opcode changes after DECODE SHALL be ignored until the next DECODE.
REQ-014 SHALL decode the captured opcode as follows: 0 add, 1 sub, 5 cmp -> aluSel 0; 2 mul -> aluSel 1; 3 div, 4 mod -> aluSel 2; 9 mov -> aluSel 3; 6 and, 7 or, 8 not -> aluSel 4; 10 lsl, 11 lsr, 12 asr -> aluSel 5; 14 ld and 15 st -> aluSel 0 (address add); 16 beq; 17 bgt; 18 b; 19 call; 20 ret.
REQ-015 SHALL treat any other opcode value (incl. 13, 21+ and upper bits when OPC_W>5) as illegal: set illegalOp=1 and go DECODE->HALT.
REQ-016 SHALL, in OPREAD (1 cycle), assert ldRegOutputData=1, then go to EXEC.
REQ-017 SHALL hold EXEC for MULDIV_LAT cycles for opcodes 2/3/4 and 1 cycle otherwise, using an internal down-counter, and assert ldResult=1 only in the final EXEC cycle.
REQ-018 SHALL assert wrFlag=1 in the final EXEC cycle for cmp only.
REQ-019 SHALL, in EXEC, set isBranchTaken=1 for opcodes 18/19/20, for 16 when flagE=1 and for 17 when flagGt=1, else 0, and hold it through WB.
REQ-020 SHALL go EXEC->MEM for ld/st and EXEC->WB otherwise.
REQ-021 SHALL, in MEM, hold memReq=1 plus isLd or isSt until the cycle memAck=1 (memAck in the first MEM cycle allowed), then go to WB; memAck outside MEM SHALL be ignored.
REQ-022 SHALL, in WB (1 cycle), assert ldPC=1, assert isRegWriteback=1 for opcodes 0-4 and 6-12 plus ld, assert isCall/isRet per opcode, then go to FETCH.
REQ-023 SHALL keep HALT until reset.

Reset
REQ-024 SHALL, while rstN=0, force state IDLE, all outputs 0, aluSel 0, illegalOp 0 and the counter 0, asynchronously, including mid-EXEC or mid-MEM (memReq drops immediately).
REQ-025 SHALL, after reset release, not leave IDLE before the first clk edge that samples start=1.

Configuration
REQ-026 SHALL, when macro MULTICYCLE_CTRL_PERF_EN is defined, add output retired out 32, reset 0, incrementing by 1 in every WB cycle and wrapping 0xFFFFFFFF->0; when undefined, the port and counter SHALL be absent.

Verification
REQ-027 SHALL cover: rstN=0 then 1, start=1 pulse, opcode=0 -> IDLE, INIT, FETCH, DECODE, OPREAD, EXEC, WB, FETCH sequence; ldResult and isRegWriteback each high 1 cycle; busy=1 from INIT.
REQ-028 SHALL cover: opcode=3 with MULDIV_LAT=4 -> EXEC 4 cycles, ldResult only in the 4th, aluSel=2.
REQ-029 SHALL cover: opcode=14, memAck delayed 3 cycles -> memReq=1 and isLd=1 for 4 cycles, then WB with isRegWriteback=1; opcode=15 -> isRegWriteback=0.
REQ-030 SHALL cover: opcode=16 with flagE=0 and then 1 -> isBranchTaken 0 and then 1 in WB; opcode=19 -> isCall=1 and isBranchTaken=1.
REQ-031 SHALL cover: opcode=13 -> illegalOp=1, HALT, busy=0, start ignored until rstN=0.
REQ-032 SHALL cover: rstN=0 asserted mid-MEM -> memReq=0 with no clk edge, state IDLE; with the macro, retired counts 3 after 3 instructions and resets to 0.
